fifo_chunk_popcnt: RTL and testbench
====================================

# fifo_chunk_popcnt

Downstream consumer of `srl_fifo`: pops `WIDTH`-bit fingerprint chunks from the FIFO read port and computes the population count of each fingerprint vector. Each vector is `CHUNKS` consecutive chunks. Completed counts go out on a valid/ready port, tagged with a wrapping vector index, toward the similarity (Tanimoto) datapath. Reads are throttled by output backpressure, so no count is ever lost.

## Interface
- `WIDTH`, 4: chunk width in bits; must equal the upstream `srl_fifo` `WIDTH`.
- `CHUNKS`, 4: chunks per fingerprint vector, ≥ 2.
- `CIDX_W`, `$clog2(CHUNKS)`: chunk index counter width.
- `POP_W`, `$clog2(WIDTH*CHUNKS+1)`: popcount result width.
- `IDX_W`, 8: vector index width.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `fifo_empty`  in  1  upstream FIFO `empty`.
- `fifo_q`  in  `WIDTH`  upstream FIFO `q`, the head item; valid while `fifo_empty`=0.
- `fifo_rd`  out  1  pop strobe to the FIFO `rd`.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  downstream accepts the result.
- `out_cnt`  out  `POP_W`  popcount of the completed vector.
- `out_idx`  out  `IDX_W`  index of the completed vector.

## Operation
- **FIFO contract (first-word fall-through).** `fifo_q` shows the head while `!fifo_empty`. A cycle with `fifo_rd`=1 consumes that head at the rising edge.
- **Pop rule.** `fifo_rd` = `!fifo_empty && !stall`. This is combinational and never asserted while empty.
- **Stall condition.** `stall` = (`cidx == CHUNKS-1`) && `out_valid` && `!out_ready`.
- **Chunk count.** `pc` = number of ones in `fifo_q`, combinational, `POP_W` bits.
- **On a pop with `cidx < CHUNKS-1`:**
  - `acc <= acc + pc`.
  - `cidx <= cidx + 1`.
- **On a pop with `cidx == CHUNKS-1`:**
  - `out_cnt <= acc + pc`; `out_idx <= vidx`; `out_valid <= 1`.
  - `acc <= 0`; `cidx <= 0`; `vidx <= vidx + 1`.
- **Width and wrap rules.**
  - `acc` is `POP_W` bits and cannot overflow, since the maximum is `WIDTH*CHUNKS`.
  - `vidx` wraps from 2^`IDX_W`-1 to 0 with no flag.
- **Output handshake.** The transfer happens on a cycle with `out_valid && out_ready`. If no new result loads on that cycle, `out_valid <= 0`.
- **Simultaneous accept and load.** When a last-chunk pop coincides with `out_valid && out_ready`, the new result replaces the old one and `out_valid` stays 1. This gives back-to-back throughput.
- **Held result.** While `out_valid && !out_ready`, `out_cnt` and `out_idx` hold stable.
- **Pipelining during backpressure.** Non-final chunks of the next vector keep being popped and accumulated. Only the final chunk is stalled.
- **FIFO empty mid-vector.** Accumulation pauses and `acc`/`cidx` hold. There is no timeout.
- **State.** The block has no FSM beyond `cidx`, `acc`, `vidx` and the output register.

## Timing
- **Reset values.** `rst`=1 at an edge gives:
  - `out_valid`=0, `out_cnt`=0, `out_idx`=0.
  - `acc`=0, `cidx`=0, `vidx`=0.
- **`fifo_rd` during reset.** `fifo_rd` is forced to 0 while `rst`=1.
- **Reset mid-vector.** A partially accumulated vector is discarded and the next popped chunk is treated as chunk 0. The FIFO contents are the upstream reset's concern.
- **Latency.** `out_valid` rises one cycle after the cycle in which the last chunk's `fifo_rd`=1.
- **Throughput.** One chunk per cycle, i.e. one vector per `CHUNKS` cycles when the FIFO is never empty and `out_ready`=1.
- **Combinational paths.** `fifo_rd` depends combinationally on `fifo_empty`, `out_ready`, `out_valid` and `cidx`. There is no combinational path from `fifo_q` to any output.

## Test plan
All scenarios use `WIDTH`=4 and `CHUNKS`=4.

1. **Reset.** Hold `rst` for 3 cycles with `fifo_empty`=0.
   - Required: `fifo_rd`=0 throughout; `out_valid`=0, `out_cnt`=0, `out_idx`=0 after release.
2. **Streaming.** Continuous chunks 0,1,…,15 (incrementing, never empty), `out_ready`=1.
   - Required counts: 4, 8, 8, 12 with `out_idx` 0, 1, 2, 3.
   - Each `out_valid` pulse lasts 1 cycle, one cycle after the 4th pop.
3. **Backpressure.** Same stream, `out_ready`=0 for 10 cycles after the first result.
   - Required: `out_cnt`=4 held.
   - Chunks 4,5,6 are popped, then `fifo_rd`=0 with chunk 7 at the head.
   - On `out_ready`=1: chunk 7 pops the same cycle and `out_cnt`=8 appears the next cycle. No vector is lost or duplicated.
4. **Empty gaps.** Chunks F,F arrive, FIFO empty for 5 cycles, then F,F.
   - Required: `fifo_rd`=0 during the gap and a single result `out_cnt`=16.
5. **Reset mid-vector.** Pop chunks F,F, pulse `rst`, then pop 1,1,1,1.
   - Required: `out_cnt`=4 and `out_idx`=0.
6. **Index wrap.** With `IDX_W`=2, stream 5 vectors.
   - Required: `out_idx` sequence 0,1,2,3,0.

Source files
------------

// File: rtl/fifo_chunk_popcnt.sv
// fifo_chunk_popcnt
// -----------------
// Pops WIDTH-bit fingerprint chunks from a first-word-fall-through FIFO,
// sums the population count of every CHUNKS consecutive chunks, and
// presents each completed vector count on a valid/ready port together
// with a wrapping vector index. The final chunk of a vector is only
// popped when the output register can take its result, so no count is
// ever dropped; earlier chunks keep flowing during backpressure.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   fifo_empty upstream FIFO empty flag
//   fifo_q     upstream FIFO head item (valid while !fifo_empty)
//   fifo_rd    pop strobe to the FIFO (combinational)
//   out_valid  result available
//   out_ready  downstream accepts the result
//   out_cnt    popcount of the completed vector
//   out_idx    index of the completed vector (wraps silently)

module fifo_chunk_popcnt #(
  parameter int WIDTH  = 4,
  parameter int CHUNKS = 4,
  parameter int CIDX_W = $clog2(CHUNKS),
  parameter int POP_W  = $clog2(WIDTH*CHUNKS+1),
  parameter int IDX_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fifo_empty,
  input  logic [WIDTH-1:0]   fifo_q,
  output logic               fifo_rd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [POP_W-1:0]   out_cnt,
  output logic [IDX_W-1:0]   out_idx
);

  localparam logic [CIDX_W-1:0] LAST_CIDX = CIDX_W'(CHUNKS-1);

  logic [CIDX_W-1:0] cidx_q, cidx_d;
  logic [POP_W-1:0]  acc_q, acc_d;
  logic [IDX_W-1:0]  vidx_q, vidx_d;
  logic              out_valid_q, out_valid_d;
  logic [POP_W-1:0]  out_cnt_q, out_cnt_d;
  logic [IDX_W-1:0]  out_idx_q, out_idx_d;

  logic [POP_W-1:0]  pc;
  logic              last_chunk;
  logic              stall;
  logic              pop;

  // Ones in the head chunk.
  // NOTE: combinational blocks use blocking '=' so each line sees the
  // value computed by the line before it within the same evaluation.
  always_comb begin
    pc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pc = pc + POP_W'(fifo_q[i]);
    end
  end

  assign last_chunk = (cidx_q == LAST_CIDX);

  // Only the final chunk waits: its result needs the output register,
  // which is still occupied by an unaccepted count.
  assign stall = last_chunk && out_valid_q && !out_ready;
  assign pop   = !rst && !fifo_empty && !stall;

  always_comb begin
    // NOTE: every signal gets its hold value first, so no path through
    // the branches below leaves it unassigned and no latch is inferred.
    cidx_d      = cidx_q;
    acc_d       = acc_q;
    vidx_d      = vidx_q;
    out_valid_d = out_valid_q;
    out_cnt_d   = out_cnt_q;
    out_idx_d   = out_idx_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (pop) begin
      if (last_chunk) begin
        // A load in the same cycle as an accept overrides the clear
        // above, giving back-to-back results.
        out_cnt_d   = acc_q + pc;
        out_idx_d   = vidx_q;
        out_valid_d = 1'b1;
        acc_d       = '0;
        cidx_d      = '0;
        vidx_d      = vidx_q + IDX_W'(1);
      end else begin
        acc_d  = acc_q + pc;
        cidx_d = cidx_q + CIDX_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking '<=' so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cidx_q      <= '0;
      acc_q       <= '0;
      vidx_q      <= '0;
      out_valid_q <= 1'b0;
      out_cnt_q   <= '0;
      out_idx_q   <= '0;
    end else begin
      cidx_q      <= cidx_d;
      acc_q       <= acc_d;
      vidx_q      <= vidx_d;
      out_valid_q <= out_valid_d;
      out_cnt_q   <= out_cnt_d;
      out_idx_q   <= out_idx_d;
    end
  end

  assign fifo_rd   = pop;
  assign out_valid = out_valid_q;
  assign out_cnt   = out_cnt_q;
  assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_fifo_chunk_popcnt.sv
// Bench for fifo_chunk_popcnt. Two instances share all inputs: one with
// an 8-bit vector index and one with a 2-bit index to exercise the wrap.
// A queue stands in for the upstream FIFO; a transaction-level model
// (results owed, chunks consumed) predicts valid, count, index and pop.

module tb_fifo_chunk_popcnt;
  localparam int WIDTH  = 4;
  localparam int CHUNKS = 4;
  localparam int POP_W  = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_q;
  logic             out_ready;

  logic             rd8, v8, rd2, v2;
  logic [POP_W-1:0] cnt8, cnt2;
  logic [7:0]       idx8;
  logic [1:0]       idx2;

  always #5 clk = ~clk;

  fifo_chunk_popcnt #(.WIDTH(WIDTH), .CHUNKS(CHUNKS), .IDX_W(8)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_q(fifo_q),
    .fifo_rd(rd8), .out_valid(v8), .out_ready(out_ready),
    .out_cnt(cnt8), .out_idx(idx8)
  );

  fifo_chunk_popcnt #(.WIDTH(WIDTH), .CHUNKS(CHUNKS), .IDX_W(2)) dut_w (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_q(fifo_q),
    .fifo_rd(rd2), .out_valid(v2), .out_ready(out_ready),
    .out_cnt(cnt2), .out_idx(idx2)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    int cnt;
    int idx;
  } res_t;

  logic [WIDTH-1:0] fq[$];        // upstream FIFO contents, head at [0]
  res_t             m_res[$];     // results the DUT owes downstream
  int               m_acc, m_pos, m_vidx;
  int               log_cnt[$], log_idx[$], log_idx2[$];
  int               valid_cycles, rd_cycles;
  bit               pend_pop;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refresh();
    fifo_empty = (fq.size() == 0);
    fifo_q     = (fq.size() > 0) ? fq[0] : '0;
  endtask

  // One clock cycle. Entered at a falling edge with inputs set; compares
  // outputs against the model, advances the model across the rising
  // edge, and returns at the next falling edge.
  task automatic tick();
    int exp_rd;
    refresh();
    #1;
    check("out_valid", v8, int'(m_res.size() > 0));
    check("out_valid_w", v2, int'(m_res.size() > 0));
    if (m_res.size() > 0) begin
      check("out_cnt", cnt8, m_res[0].cnt);
      check("out_idx", idx8, m_res[0].idx % 256);
      check("out_cnt_w", cnt2, m_res[0].cnt);
      check("out_idx_w", idx2, m_res[0].idx % 4);
    end
    exp_rd = int'(!rst && fq.size() > 0 &&
                  !(m_pos == CHUNKS-1 && m_res.size() > 0 && !out_ready));
    check("fifo_rd", rd8, exp_rd);
    check("fifo_rd_w", rd2, exp_rd);

    if (!rst && v8 && out_ready) begin
      log_cnt.push_back(int'(cnt8));
      log_idx.push_back(int'(idx8));
    end
    if (!rst && v2 && out_ready) log_idx2.push_back(int'(idx2));
    if (v8) valid_cycles++;
    if (rd8) rd_cycles++;

    if (rst) begin
      m_res.delete();
      m_acc = 0; m_pos = 0; m_vidx = 0;
    end else begin
      if (m_res.size() > 0 && out_ready) void'(m_res.pop_front());
      if (rd8 && fq.size() > 0) begin
        m_acc += $countones(fq[0]);
        m_pos++;
        if (m_pos == CHUNKS) begin
          m_res.push_back('{cnt: m_acc, idx: m_vidx});
          m_vidx++;
          m_acc = 0;
          m_pos = 0;
        end
      end
    end
    pend_pop = rd8 && fq.size() > 0;
    @(negedge clk);
    if (pend_pop) void'(fq.pop_front());
    refresh();
  endtask

  task automatic clear_logs();
    log_cnt.delete(); log_idx.delete(); log_idx2.delete();
    valid_cycles = 0; rd_cycles = 0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    fq.delete();
    tick();
    tick();
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      if (fq.size() == 0 && !v8 && m_res.size() == 0) done = 1'b1;
      else tick();
    end
    check("drain_done", int'(done), 1);
  endtask

  task automatic check_stream_log(input string tag);
    int exp_c[4] = '{4, 8, 8, 12};
    check({tag, "_n"}, log_cnt.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check({tag, "_cnt"}, (i < log_cnt.size()) ? log_cnt[i] : -1, exp_c[i]);
      check({tag, "_idx"}, (i < log_idx.size()) ? log_idx[i] : -1, i);
    end
  endtask

  initial begin
    bit seen;
    int exp_w[5] = '{0, 1, 2, 3, 0};
    rst = 1'b1; out_ready = 1'b0; fifo_empty = 1'b1; fifo_q = '0;
    m_acc = 0; m_pos = 0; m_vidx = 0;
    clear_logs();
    @(negedge clk);

    // 1. Reset held 3 cycles with a non-empty FIFO.
    out_ready = 1'b1;
    fq.push_back(4'hA); fq.push_back(4'hB);
    rd_cycles = 0;
    repeat (3) tick();
    check("rst_no_pop", rd_cycles, 0);
    rst = 1'b0;
    check("rst_valid", v8, 0);
    check("rst_cnt", cnt8, 0);
    check("rst_idx", idx8, 0);
    fq.delete();
    refresh();

    // 2. Streaming 0..15 with out_ready high.
    reset_dut();
    for (int i = 0; i < 16; i++) fq.push_back(4'(i));
    drain();
    check_stream_log("stream");
    check("stream_valid_cycles", valid_cycles, 4);

    // 3. Backpressure right after the first result.
    reset_dut();
    for (int i = 0; i < 16; i++) fq.push_back(4'(i));
    out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = v8;
    end
    check("bp_first_valid", int'(seen), 1);
    out_ready = 1'b0;
    repeat (10) tick();
    check("bp_hold_valid", v8, 1);
    check("bp_hold_cnt", cnt8, 4);
    check("bp_head", fifo_q, 7);
    check("bp_stalled_rd", rd8, 0);
    check("bp_left", fq.size(), 9);
    out_ready = 1'b1;
    #1;
    check("bp_resume_rd", rd8, 1);
    tick();
    check("bp_next_valid", v8, 1);
    check("bp_next_cnt", cnt8, 8);
    check("bp_next_idx", idx8, 1);
    drain();
    check_stream_log("bp");

    // 4. Empty gap mid-vector.
    reset_dut();
    out_ready = 1'b1;
    fq.push_back(4'hF); fq.push_back(4'hF);
    tick(); tick();
    rd_cycles = 0;
    repeat (5) tick();
    check("gap_no_pop", rd_cycles, 0);
    fq.push_back(4'hF); fq.push_back(4'hF);
    drain();
    check("gap_n", log_cnt.size(), 1);
    check("gap_cnt", (log_cnt.size() > 0) ? log_cnt[0] : -1, 16);

    // 5. Reset with a partial vector accumulated.
    reset_dut();
    out_ready = 1'b1;
    fq.push_back(4'hF); fq.push_back(4'hF);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) fq.push_back(4'h1);
    drain();
    check("midrst_n", log_cnt.size(), 1);
    check("midrst_cnt", (log_cnt.size() > 0) ? log_cnt[0] : -1, 4);
    check("midrst_idx", (log_idx.size() > 0) ? log_idx[0] : -1, 0);

    // 6. Index wrap on the 2-bit instance.
    reset_dut();
    for (int i = 0; i < 20; i++) fq.push_back(4'($urandom_range(15, 0)));
    drain();
    check("wrap_n", log_idx2.size(), 5);
    for (int i = 0; i < 5; i++)
      check("wrap_idx", (i < log_idx2.size()) ? log_idx2[i] : -1, exp_w[i]);

    // Random traffic: bursts, gaps and backpressure; long enough to wrap
    // the 8-bit index as well.
    reset_dut();
    for (int c = 0; c < 3000; c++) begin
      if (fq.size() < 8 && $urandom_range(3, 0) != 0)
        fq.push_back(4'($urandom_range(15, 0)));
      out_ready = ($urandom_range(3, 0) != 0);
      tick();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
